fp_div: RTL
===========

Name: fp_div

Overview:
- Sequential IEEE-754 single-precision divider; the inverse operation to the team's FP multiplier, sharing its operand format and its hidden-one and zero conventions.
- Mantissa quotient is produced by a restoring shift-subtract loop, one quotient bit per cycle, with a start/done handshake.
- Sits beside the multiplier in the FP datapath; every operation has the same fixed latency, so schedulers can treat it as a fixed-delay unit.

Parameters:
- QBITS, 26, quotient bits generated (weights 2^0 down to 2^-25); fixes the CALC length. Only 26 is supported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend, IEEE single
- b  input  32  divisor, IEEE single
- c  output  32  quotient, IEEE single; registered, holds until the next done
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; c is valid in the same cycle
- dz  output  1  divide-by-zero flag; valid with done, holds with c

Behaviour:
- Reset (rst=0, async): state=IDLE, c=0, busy=0, done=0, dz=0, internal registers cleared. Reset mid-operation aborts it; no done is produced.
- Operand fields: exp=[30:23], mant={1,[22:0]}, sign=[31]. exp==0 means zero (denormals flushed). Exp 255 gets no special NaN/Inf handling.
- IDLE: when start=1, latch a and b, then go to CALC. busy rises next cycle. a and b are don't-care afterwards.
- start while busy is ignored.
- CALC, 26 cycles:
  - Init: remainder R=ma (26 bit), divisor D=mb.
  - Each cycle: if R>=D then q bit=1 and R=R-D, else q bit=0; then R=R<<1.
  - q[25] (weight 2^0) is produced first.
- NORM, 1 cycle; compute the result and register c and dz:
  - sign = sa^sb.
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(R!=0), E=ea-eb+127.
  - Else: mant=q[23:1], guard=q[0], sticky=(R!=0), E=ea-eb+126.
  - E is computed as 10-bit signed.
  - Special cases, in priority order:
    1. ea==0: c={sign,31'b0}, dz=0.
    2. eb==0: c={sign,8'hFF,23'b0}, dz=1.
    3. E>=255 after rounding: c={sign,8'hFF,23'b0}, dz=0.
    4. E<=0: c={sign,31'b0}, dz=0.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge N gives done=1 in the cycle after edge N+28.
- Back-to-back: start may be asserted during the done cycle. It is sampled at the next edge, when the block is back in IDLE.

Optional Feature:
- Macro FP_DIV_ROUND_EN.
- Defined: round-to-nearest-even. Increment mant if guard & (sticky | mant[0]). If mant overflows to 0, increment E, which may then trigger the overflow case.
- Not defined: truncation. Guard and sticky are ignored. The CALC length is unchanged (26 cycles) in both builds.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start pulse -> done exactly 28 cycles after the start edge, c=0x40400000, dz=0, busy high for 27 cycles.
- a=0x3F800000, b=0x40400000 (1/3) -> c=0x3EAAAAAA without FP_DIV_ROUND_EN; c=0x3EAAAAAB with it.
- a=0x3F800000, b=0x00000000 -> c=0x7F800000, dz=1. Then a=0x00000000, b=0x00000000 -> c=0x00000000, dz=0.
- a=0xBF800000 (-1.0), b=0x3F000000 (0.5) -> c=0xC0000000. a=0x7F000000, b=0x3F000000 -> c=0x7F800000 (overflow), dz=0. a=0x00800000, b=0x40000000 -> c=0x00000000 (underflow).
- Assert start again, with different a/b, 5 cycles into an operation -> ignored: the first result is unchanged and exactly one done pulse occurs.
- Pull rst low 10 cycles into an operation -> c=0, busy=0, done=0 immediately, with no later done. A new start after release completes normally.

Source files
------------

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider: restoring shift-subtract, one quotient bit per cycle.
// Optional round-to-nearest-even under FP_DIV_ROUND_EN; truncation otherwise.
module fp_div #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [25:0] r_q, r_d;
  logic [23:0] d_q;
  logic [25:0] q_q;
  logic [4:0]  cnt_q;
  logic        sgn_q;
  logic [7:0]  ea_q, eb_q;
  logic [31:0] c_q, c_d;
  logic        dz_q, dz_d, done_q;
  logic        ge;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 5'(QBITS - 1)) state_d = NORM;
      NORM:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Remainder stays below 2*D, so the left shift never loses a set bit.
  assign ge  = (r_q >= {2'b0, d_q});
  assign r_d = (ge ? r_q - {2'b0, d_q} : r_q) << 1;

  logic signed [9:0] e_n, e_r;
  logic [22:0] mant;
  logic        guard, sticky;
  logic [23:0] mant_r;

  always_comb begin
    if (q_q[25]) begin
      mant   = q_q[24:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|r_q);
      e_n    = $signed({2'b0, ea_q}) - $signed({2'b0, eb_q}) + 10'sd127;
    end else begin
      mant   = q_q[23:1];
      guard  = q_q[0];
      sticky = |r_q;
      e_n    = $signed({2'b0, ea_q}) - $signed({2'b0, eb_q}) + 10'sd126;
    end
`ifdef FP_DIV_ROUND_EN
    mant_r = {1'b0, mant} + {23'b0, guard & (sticky | mant[0])};
    e_r    = e_n + $signed({9'b0, mant_r[23]});
`else
    mant_r = {1'b0, mant};
    e_r    = e_n;
`endif
    dz_d = 1'b0;
    if (ea_q == 8'd0)            c_d = {sgn_q, 31'b0};
    else if (eb_q == 8'd0) begin c_d = {sgn_q, 8'hFF, 23'b0}; dz_d = 1'b1; end
    else if (e_r >= 10'sd255)    c_d = {sgn_q, 8'hFF, 23'b0};
    else if (e_r <= 10'sd0)      c_d = {sgn_q, 31'b0};
    else                         c_d = {sgn_q, e_r[7:0], mant_r[22:0]};
  end

`ifndef FP_DIV_ROUND_EN
  // Truncation ignores the round bits; keep them visible without feeding logic.
  logic unused_rnd;
  assign unused_rnd = guard ^ sticky;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      case (state_q)
        IDLE: if (start) begin
          r_q   <= {2'b01, a[22:0]};
          d_q   <= {1'b1, b[22:0]};
          q_q   <= '0;
          cnt_q <= '0;
          sgn_q <= a[31] ^ b[31];
          ea_q  <= a[30:23];
          eb_q  <= b[30:23];
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= {q_q[24:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
          c_q  <= c_d;
          dz_q <= dz_d;
        end
        default: ;
      endcase
    end
  end

  assign c    = c_q;
  assign dz   = dz_q;
  assign done = done_q;
  assign busy = (state_q == CALC) || (state_q == NORM);

endmodule
